shared_resource_arbiter: RTL and testbench

SHARED_RESOURCE_ARBITER -- requirements
Module: shared_resource_arbiter

---
 rtl/shared_resource_arbiter.sv | 136 +++++++++++++
 tb/tb_shared_resource_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/shared_resource_arbiter.sv
// Purpose: round-robin arbiter giving NUM_CH requesters lookup access to a shared, writable DEPTH-entry table.
// Latency: response registered 1 cycle after the grant handshake; table writes take effect from the next cycle.
// Backpressure: a held response with rsp_ready low blocks all grants; writes are never stalled.
module shared_resource_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 32,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    output logic [NUM_CH-1:0]        req_ready,
    output logic                     rsp_valid,
    output logic [CH_W-1:0]          rsp_ch,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err,
    input  logic                     rsp_ready,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [15:0]              grant_count
);

    // Table index width, and a widened address width so DEPTH (up to 256) always fits the range compare.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AE_W  = (ADDR_W > 9) ? ADDR_W : 9;
    localparam logic [AE_W-1:0] DEPTH_E = AE_W'(DEPTH);

    // Addresses are 1-based: 1..DEPTH map onto entries 0..DEPTH-1; 0 and anything above DEPTH miss.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        logic [AE_W-1:0] ae;
        ae = AE_W'(a);
        return (ae != '0) && (ae <= DEPTH_E);
    endfunction

    function automatic logic [IDX_W-1:0] addr_to_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a - ADDR_W'(1));
    endfunction

    logic [DATA_W-1:0] table_q [DEPTH];
    logic [CH_W-1:0]   last_ptr;

    logic              arb_found;
    int                arb_idx;
    logic [CH_W-1:0]   grant_idx;
    logic [NUM_CH-1:0] grant_oh;
    logic              can_accept;
    logic              accept;

    logic [ADDR_W-1:0] sel_addr;
    logic              sel_ok;
    logic [IDX_W-1:0]  sel_idx;
    logic              wr_ok;
    logic [IDX_W-1:0]  wr_idx;

    // Round-robin search starting one past the last granted channel; first requester wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = 0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            arb_idx = (int'(last_ptr) + k) % NUM_CH;
            if (!arb_found && req_valid[arb_idx]) begin
                arb_found         = 1'b1;
                grant_idx         = CH_W'(arb_idx);
                grant_oh[arb_idx] = 1'b1;
            end
        end
    end

    // Grant only when the output stage is free or draining this cycle; addresses never feed this path.
    assign can_accept = !reset && (!rsp_valid || rsp_ready);
    assign req_ready  = can_accept ? grant_oh : '0;
    assign accept     = can_accept && arb_found;

    // Steer the winning channel's address into the table lookup.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == CH_W'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign sel_ok  = addr_in_range(sel_addr);
    assign sel_idx = sel_ok ? addr_to_idx(sel_addr) : '0;
    assign wr_ok   = addr_in_range(wr_addr);
    assign wr_idx  = wr_ok ? addr_to_idx(wr_addr) : '0;

    // Table storage; a write lands at the edge, so a same-cycle lookup still captures the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                table_q[e] <= '0;
            end
        end else if (wr_en && wr_ok) begin
            table_q[wr_idx] <= wr_data;
        end
    end

    // Output stage: load on an accepted request, otherwise hold until the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_ch    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_ch    <= grant_idx;
            rsp_data  <= sel_ok ? table_q[sel_idx] : '1;
            rsp_err   <= !sel_ok;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Round-robin pointer and saturating grant counter advance only on a handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_ptr    <= CH_W'(NUM_CH - 1);
            grant_count <= '0;
        end else if (accept) begin
            last_ptr <= grant_idx;
            if (grant_count != 16'hFFFF) begin
                grant_count <= grant_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Purpose: directed bench for shared_resource_arbiter with hand-computed expectations.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 2ns after it.
// Backpressure: rsp_ready is driven explicitly by each scenario.
module tb_shared_resource_arbiter;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    req_valid;
    logic [127:0]  req_addr;
    logic [3:0]    req_ready;
    logic          rsp_valid;
    logic [1:0]    rsp_ch;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          rsp_ready;
    logic          wr_en;
    logic [31:0]   wr_addr;
    logic [31:0]   wr_data;
    logic [15:0]   grant_count;

    int n_checks = 0;
    int n_pass   = 0;

    shared_resource_arbiter #(
        .NUM_CH(4), .DATA_W(32), .ADDR_W(32), .DEPTH(32)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .grant_count(grant_count)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts the check, reports a mismatch.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; return 1ns after the edge so new inputs can be driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic set_addr(input int ch, input logic [31:0] a);
        req_addr[ch*32 +: 32] = a;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 4'hF; req_addr = '0; rsp_ready = 1'b1;
        wr_en = 1'b1; wr_addr = 32'd5; wr_data = 32'h99;

        // Reset: no grants, writes ignored while reset is high.
        step(); settle();
        check("ready_in_reset", {28'd0, req_ready}, 32'h0);
        step();
        reset = 1'b0; req_valid = 4'h0; wr_en = 1'b0; settle();
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_ch", {30'd0, rsp_ch}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_gcount", {16'd0, grant_count}, 32'd0);

        // Entry 5 must still be 0 (write during reset ignored); ch0 goes first.
        req_valid = 4'b0001; set_addr(0, 32'd5); settle();
        check("first_grant_ch0", {28'd0, req_ready}, 32'b0001);
        step(); req_valid = 4'h0; settle();
        check("rd5_after_reset", rsp_data, 32'd0);
        check("rd5_ch", {30'd0, rsp_ch}, 32'd0);

        // Write 0x1C to addr 5, then ch2 looks it up.
        do_write(32'd5, 32'h1C); settle();
        check("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
        req_valid = 4'b0100; set_addr(2, 32'd5); settle();
        check("ch2_ready", {28'd0, req_ready}, 32'b0100);
        step(); req_valid = 4'h0; settle();
        check("ch2_valid", {31'd0, rsp_valid}, 32'd1);
        check("ch2_ch", {30'd0, rsp_ch}, 32'd2);
        check("ch2_data", rsp_data, 32'h1C);
        check("ch2_err", {31'd0, rsp_err}, 32'd0);

        // Round robin from a fresh reset: 0,1,2,3,0, one response per cycle.
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 4; i++) do_write(32'(i + 1), 32'h100 + 32'(i));
        for (int i = 0; i < 4; i++) set_addr(i, 32'(i + 1));
        req_valid = 4'hF; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("rr_ready", {28'd0, req_ready}, 32'(1 << (k % 4)));
            step();
            check("rr_valid", {31'd0, rsp_valid}, 32'd1);
            check("rr_ch", {30'd0, rsp_ch}, 32'(k % 4));
            check("rr_data", rsp_data, 32'h100 + 32'(k % 4));
        end
        req_valid = 4'h0; settle();
        check("rr_gcount", {16'd0, grant_count}, 32'd5);

        // Out-of-range lookups from ch1: address 0 and address 33.
        req_valid = 4'b0010; set_addr(1, 32'd0);
        step(); settle();
        check("oor0_ch", {30'd0, rsp_ch}, 32'd1);
        check("oor0_data", rsp_data, 32'hFFFF_FFFF);
        check("oor0_err", {31'd0, rsp_err}, 32'd1);
        set_addr(1, 32'd33);
        step(); req_valid = 4'h0; settle();
        check("oor33_data", rsp_data, 32'hFFFF_FFFF);
        check("oor33_err", {31'd0, rsp_err}, 32'd1);

        // Backpressure: response held, no grants; release grants ch3 (pointer at 1).
        rsp_ready = 1'b0; req_valid = 4'b1001; set_addr(0, 32'd1); set_addr(3, 32'd4);
        for (int k = 0; k < 3; k++) begin
            settle();
            check("hold_ready", {28'd0, req_ready}, 32'd0);
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_ch", {30'd0, rsp_ch}, 32'd1);
            check("hold_data", rsp_data, 32'hFFFF_FFFF);
            check("hold_err", {31'd0, rsp_err}, 32'd1);
            step();
        end
        rsp_ready = 1'b1; settle();
        check("release_ch3", {28'd0, req_ready}, 32'b1000);
        step(); settle();
        check("bp_ch3_ch", {30'd0, rsp_ch}, 32'd3);
        check("bp_ch3_data", rsp_data, 32'h103);
        check("bp_ch3_err", {31'd0, rsp_err}, 32'd0);
        check("next_ch0", {28'd0, req_ready}, 32'b0001);
        step(); req_valid = 4'h0; settle();
        check("bp_ch0_data", rsp_data, 32'h100);
        step(); settle();
        check("drained", {31'd0, rsp_valid}, 32'd0);
        check("bp_gcount", {16'd0, grant_count}, 32'd9);

        // Same-cycle write and lookup of addr 7 returns the old value.
        do_write(32'd7, 32'h56);
        wr_en = 1'b1; wr_addr = 32'd7; wr_data = 32'h2B;
        req_valid = 4'b0001; set_addr(0, 32'd7);
        step(); wr_en = 1'b0; settle();
        check("raw_old", rsp_data, 32'h56);
        step(); req_valid = 4'h0; settle();
        check("raw_new", rsp_data, 32'h2B);
        check("raw_gcount", {16'd0, grant_count}, 32'd11);

        // Reset with a pending response: discarded, table and counter cleared.
        rsp_ready = 1'b0; reset = 1'b1; req_valid = 4'hF; settle();
        check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        check("rst2_ready", {28'd0, req_ready}, 32'd0);
        step(); reset = 1'b0; rsp_ready = 1'b1; set_addr(0, 32'd5); settle();
        check("rst2_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst2_gcount", {16'd0, grant_count}, 32'd0);
        check("rst2_first_ch0", {28'd0, req_ready}, 32'b0001);
        step(); req_valid = 4'h0; settle();
        check("rst2_ch", {30'd0, rsp_ch}, 32'd0);
        check("rst2_e5", rsp_data, 32'd0);
        check("rst2_gcount1", {16'd0, grant_count}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
